// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and load producers in, register-file write port out.
// Bypass read ports exist only when WB_BYPASS_EN is defined.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [2:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_wa;
  logic [31:0] ld_wd;
  logic        we;
  logic [2:0]  wa;
  logic [31:0] wd;
  logic [7:0]  pend;
`ifdef WB_BYPASS_EN
  logic [2:0]  ra1;
  logic [2:0]  ra2;
  logic [31:0] rd1_in;
  logic [31:0] rd2_in;
  logic [31:0] rd1_fwd;
  logic [31:0] rd2_fwd;

  modport master (
    input  alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd, ra1, ra2, rd1_in, rd2_in,
    output alu_stall, ld_ready, we, wa, wd, pend, rd1_fwd, rd2_fwd
  );
  modport slave (
    output alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd, ra1, ra2, rd1_in, rd2_in,
    input  alu_stall, ld_ready, we, wa, wd, pend, rd1_fwd, rd2_fwd
  );
`else
  modport master (
    input  alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
    output alu_stall, ld_ready, we, wa, wd, pend
  );
  modport slave (
    output alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
    input  alu_stall, ld_ready, we, wa, wd, pend
  );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU-priority merge of ALU and buffered load results onto the
// register-file write port, with a starvation guard. Optional macro: WB_BYPASS_EN.
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  wb_arbiter_if.master io_bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

  logic [2:0]    r_fifo_wa [DEPTH];
  logic [31:0]   r_fifo_wd [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_starve_cnt;
  logic          r_alu_stall;
  logic          r_we;
  logic [2:0]    r_wa;
  logic [31:0]   r_wd;

  logic          w_empty;
  logic          w_full;
  logic          w_ld_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_alu_win;
  logic [3:0]    w_starve_next;
  logic [7:0]    w_entry_dec [DEPTH];
  logic [7:0]    w_pend;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_ld_ready = n_rst && !w_full;
  assign w_push     = io_bus.ld_valid && w_ld_ready;
  // A stall cycle always drains; otherwise the ALU owns the port whenever it offers.
  assign w_pop      = !w_empty && (r_alu_stall || !io_bus.alu_valid);
  assign w_alu_win  = io_bus.alu_valid && !w_pop;

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (w_pop || w_empty) begin
      w_starve_next = 4'd0;
    end else if (w_alu_win) begin
      w_starve_next = r_starve_cnt + 4'd1;
    end
  end

  // Entry gi is live when its distance from the read pointer is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] w_offset;
      logic          w_valid;
      assign w_offset        = AW'(gi) - r_rd_ptr;
      assign w_valid         = ({1'b0, w_offset} < r_count);
      assign w_entry_dec[gi] = w_valid ? (8'b1 << r_fifo_wa[gi]) : 8'b0;
    end
  endgenerate

  always_comb begin
    w_pend = 8'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend = w_pend | w_entry_dec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wa[r_wr_ptr] <= io_bus.ld_wa;
      r_fifo_wd[r_wr_ptr] <= io_bus.ld_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_starve_cnt <= 4'd0;
      r_alu_stall  <= 1'b0;
      r_we         <= 1'b0;
      r_wa         <= 3'd0;
      r_wd         <= 32'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count      <= r_count + CW'(w_push) - CW'(w_pop);
      r_starve_cnt <= w_starve_next;
      r_alu_stall  <= (w_starve_next == STARVE_LIM);
      if (w_pop) begin
        r_we <= 1'b1;
        r_wa <= r_fifo_wa[r_rd_ptr];
        r_wd <= r_fifo_wd[r_rd_ptr];
      end else if (w_alu_win) begin
        r_we <= 1'b1;
        r_wa <= io_bus.alu_wa;
        r_wd <= io_bus.alu_wd;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign io_bus.alu_stall = r_alu_stall;
  assign io_bus.ld_ready  = w_ld_ready;
  assign io_bus.we        = r_we;
  assign io_bus.wa        = r_wa;
  assign io_bus.wd        = r_wd;
  assign io_bus.pend      = w_pend;

`ifdef WB_BYPASS_EN
  // Covers the cycle where the write is on the port but not yet in the file.
  assign io_bus.rd1_fwd = (r_we && r_wa == io_bus.ra1) ? r_wd : io_bus.rd1_in;
  assign io_bus.rd2_fwd = (r_we && r_wa == io_bus.ra2) ? r_wd : io_bus.rd2_in;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 4;
  localparam int NV         = 10;

  typedef struct packed {
    logic [2:0]  wa;
    logic [31:0] wd;
  } ent_t;

  typedef struct {
    logic        rst_n;
    logic        av;
    logic [2:0]  awa;
    logic [31:0] awd;
    logic        lv;
    logic [2:0]  lwa;
    logic [31:0] lwd;
    logic        ewe;
    logic [2:0]  ewa;
    logic [31:0] ewd;
    logic        erdy;
    logic [7:0]  epend;
    logic        estall;
  } vec_t;

  logic clk;
  logic n_rst;
  wb_arbiter_if bus();

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, as seen just after each rising edge.
  ent_t        m_q[$];
  int          m_starve = 0;
  bit          m_stall  = 0;
  logic        m_we     = 1'b0;
  logic [2:0]  m_wa     = 3'd0;
  logic [31:0] m_wd     = 32'd0;

  logic [31:0] rf [8];
  always @(posedge clk) begin
    if (bus.we === 1'b1) rf[bus.wa] <= bus.wd;
  end

  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic av, logic [2:0] awa, logic [31:0] awd,
                              logic lv, logic [2:0] lwa, logic [31:0] lwd,
                              logic ewe, logic [2:0] ewa, logic [31:0] ewd,
                              logic erdy, logic [7:0] ep, logic es);
    vec_t v;
    v.rst_n = r;  v.av = av;  v.awa = awa;  v.awd = awd;
    v.lv = lv;    v.lwa = lwa; v.lwd = lwd;
    v.ewe = ewe;  v.ewa = ewa; v.ewd = ewd;
    v.erdy = erdy; v.epend = ep; v.estall = es;
    return v;
  endfunction

  function automatic logic [7:0] model_pend();
    logic [7:0] p;
    p = 8'b0;
    foreach (m_q[i]) p[m_q[i].wa] = 1'b1;
    return p;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock: derive the model's next state from the rules, then step.
  task automatic tick();
    bit          rdy, nonempty, pop, alu, push;
    int          s_next;
    logic        we_n;
    logic [2:0]  wa_n;
    logic [31:0] wd_n;
    logic [7:0]  p;
    ent_t        e;
    p = model_pend();
    if (n_rst && bus.alu_valid && p[bus.alu_wa])
      $display("protocol violation: ALU write to pending reg %0d", bus.alu_wa);
    rdy  = n_rst && (m_q.size() < DEPTH);
    e.wa = bus.ld_wa;
    e.wd = bus.ld_wd;
    if (!n_rst) begin
      @(posedge clk); #1;
      m_q.delete();
      m_starve = 0; m_stall = 0;
      m_we = 1'b0; m_wa = 3'd0; m_wd = 32'd0;
    end else begin
      nonempty = (m_q.size() != 0);
      pop      = nonempty && (m_stall || !bus.alu_valid);
      alu      = !pop && bus.alu_valid;
      push     = bus.ld_valid && rdy;
      we_n = m_we; wa_n = m_wa; wd_n = m_wd;
      if (pop) begin
        we_n = 1'b1; wa_n = m_q[0].wa; wd_n = m_q[0].wd;
      end else if (alu) begin
        we_n = 1'b1; wa_n = bus.alu_wa; wd_n = bus.alu_wd;
      end else begin
        we_n = 1'b0;
      end
      if (pop || !nonempty) s_next = 0;
      else if (alu)         s_next = m_starve + 1;
      else                  s_next = m_starve;
      @(posedge clk); #1;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(e);
      m_starve = s_next;
      m_stall  = (s_next == STARVE_MAX);
      m_we = we_n; m_wa = wa_n; m_wd = wd_n;
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, "_we"},    {31'd0, bus.we},        {31'd0, m_we});
    chk({tag, "_wa"},    {29'd0, bus.wa},        {29'd0, m_wa});
    chk({tag, "_wd"},    bus.wd,                 m_wd);
    chk({tag, "_pend"},  {24'd0, bus.pend},      {24'd0, model_pend()});
    chk({tag, "_ready"}, {31'd0, bus.ld_ready},  {31'd0, (n_rst && m_q.size() < DEPTH)});
    chk({tag, "_stall"}, {31'd0, bus.alu_stall}, {31'd0, m_stall});
  endtask

  task automatic drive(logic av, logic [2:0] awa, logic [31:0] awd,
                       logic lv, logic [2:0] lwa, logic [31:0] lwd);
    bus.alu_valid = av; bus.alu_wa = awa; bus.alu_wd = awd;
    bus.ld_valid  = lv; bus.ld_wa  = lwa; bus.ld_wd  = lwd;
  endtask

  initial begin
    logic [7:0] p;
    logic [2:0] a;
    n_rst = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
`ifdef WB_BYPASS_EN
    bus.ra1 = 3'd0; bus.ra2 = 3'd0; bus.rd1_in = 32'd0; bus.rd2_in = 32'd0;
`endif
    #2;

    //           rst av awa  awd           lv lwa  lwd       we wa   wd            rdy pend   stall
    tbl[0] = mk(0, 1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 32'h0,  0, 3'd0, 32'h0,        0, 8'h00, 0);
    tbl[1] = mk(0, 1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 32'h0,  0, 3'd0, 32'h0,        0, 8'h00, 0);
    tbl[2] = mk(1, 1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 32'h0,  1, 3'd3, 32'hDEADBEEF, 1, 8'h00, 0);
    tbl[3] = mk(1, 0, 3'd0, 32'h0,        0, 3'd0, 32'h0,  0, 3'd3, 32'hDEADBEEF, 1, 8'h00, 0);
    tbl[4] = mk(1, 0, 3'd0, 32'h0,        1, 3'd1, 32'h11, 0, 3'd3, 32'hDEADBEEF, 1, 8'h02, 0);
    tbl[5] = mk(1, 0, 3'd0, 32'h0,        1, 3'd2, 32'h22, 1, 3'd1, 32'h11,       1, 8'h04, 0);
    tbl[6] = mk(1, 0, 3'd0, 32'h0,        0, 3'd0, 32'h0,  1, 3'd2, 32'h22,       1, 8'h00, 0);
    tbl[7] = mk(1, 0, 3'd0, 32'h0,        0, 3'd0, 32'h0,  0, 3'd2, 32'h22,       1, 8'h00, 0);
    tbl[8] = mk(1, 1, 3'd4, 32'h44,       1, 3'd5, 32'h55, 1, 3'd4, 32'h44,       1, 8'h20, 0);
    tbl[9] = mk(1, 0, 3'd0, 32'h0,        0, 3'd0, 32'h0,  1, 3'd5, 32'h55,       1, 8'h00, 0);

    for (int i = 0; i < NV; i++) begin
      n_rst = tbl[i].rst_n;
      drive(tbl[i].av, tbl[i].awa, tbl[i].awd, tbl[i].lv, tbl[i].lwa, tbl[i].lwd);
      tick();
      chk($sformatf("tbl%0d_we", i),    {31'd0, bus.we},        {31'd0, tbl[i].ewe});
      chk($sformatf("tbl%0d_wa", i),    {29'd0, bus.wa},        {29'd0, tbl[i].ewa});
      chk($sformatf("tbl%0d_wd", i),    bus.wd,                 tbl[i].ewd);
      chk($sformatf("tbl%0d_ready", i), {31'd0, bus.ld_ready},  {31'd0, tbl[i].erdy});
      chk($sformatf("tbl%0d_pend", i),  {24'd0, bus.pend},      {24'd0, tbl[i].epend});
      chk($sformatf("tbl%0d_stall", i), {31'd0, bus.alu_stall}, {31'd0, tbl[i].estall});
      if (i == 3) chk("rf_alu_write", rf[3], 32'hDEADBEEF);
    end

    // Loads with no ALU traffic drain in arrival order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'd0, 32'd0, 1'b1, 3'(i + 1), 32'h100 + 32'(i));
      tick();
      check_model($sformatf("drain%0d", i));
      if (i > 0) chk($sformatf("drain%0d_order", i), {29'd0, bus.wa}, 32'(i));
    end
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    tick();
    check_model("drain4");
    chk("drain4_order", {29'd0, bus.wa}, 32'd4);
    chk("drain4_data", bus.wd, 32'h103);

    // Fill under constant ALU traffic, then forced drain while full.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'd7, 32'h700 + 32'(k), 1'b1, 3'(k + 1), 32'h200 + 32'(k));
      tick();
      check_model($sformatf("fill%0d", k));
    end
    chk("full_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("full_pend",  {24'd0, bus.pend},     32'h1E);
    drive(1'b1, 3'd7, 32'h704, 1'b1, 3'd6, 32'h206);
    tick();
    check_model("full4");
    chk("full4_stall", {31'd0, bus.alu_stall}, 32'd1);
    chk("full4_wa",    {29'd0, bus.wa},        32'd7);
    drive(1'b1, 3'd7, 32'h705, 1'b1, 3'd6, 32'h206);
    tick();
    check_model("full5");
    chk("popfull_wa",    {29'd0, bus.wa},       32'd1);
    chk("popfull_pend",  {24'd0, bus.pend},     32'h1C);
    chk("popfull_ready", {31'd0, bus.ld_ready}, 32'd1);
    drive(1'b1, 3'd7, 32'h706, 1'b1, 3'd6, 32'h206);
    tick();
    check_model("full6");
    chk("refill_pend", {24'd0, bus.pend}, 32'h5C);

    // Reset with loads queued: they are discarded, never written.
    n_rst = 1'b0;
    drive(1'b1, 3'd7, 32'h777, 1'b0, 3'd0, 32'd0);
    tick();
    chk("midrst_pend",  {24'd0, bus.pend},     32'd0);
    chk("midrst_we",    {31'd0, bus.we},       32'd0);
    chk("midrst_ready", {31'd0, bus.ld_ready}, 32'd0);
    n_rst = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_model($sformatf("postrst%0d", k));
      chk($sformatf("postrst%0d_we", k), {31'd0, bus.we}, 32'd0);
    end

    // Starvation: one load to r5 against continuous ALU writes to r2.
    drive(1'b0, 3'd0, 32'd0, 1'b1, 3'd5, 32'h55);
    tick();
    check_model("starve0");
    chk("starve0_pend", {24'd0, bus.pend}, 32'h20);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 3'd2, 32'h300 + 32'(k), 1'b0, 3'd0, 32'd0);
      tick();
      check_model($sformatf("starve%0d", k));
      if (k <= 4) begin
        chk($sformatf("starve%0d_wa", k),    {29'd0, bus.wa},        32'd2);
        chk($sformatf("starve%0d_stall", k), {31'd0, bus.alu_stall}, (k == 4) ? 32'd1 : 32'd0);
      end else if (k == 5) begin
        chk("forced_wa",    {29'd0, bus.wa},        32'd5);
        chk("forced_wd",    bus.wd,                 32'h55);
        chk("forced_stall", {31'd0, bus.alu_stall}, 32'd0);
      end else begin
        chk("resume_wd", bus.wd, 32'h306);
      end
    end

    // Randomized traffic; ALU destinations avoid registers with queued loads.
    for (int c = 0; c < 500; c++) begin
      n_rst = ($urandom_range(0, 79) != 0);
      p = model_pend();
      a = 3'($urandom_range(0, 7));
      while (p[a]) a = a + 3'd1;
      drive(($urandom_range(0, 99) < 65), a, $urandom(),
            ($urandom_range(0, 99) < 55), 3'($urandom_range(0, 7)), $urandom());
      tick();
      check_model($sformatf("rnd%0d", c));
    end

`ifdef WB_BYPASS_EN
    n_rst = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    tick();
    n_rst = 1'b1;
    drive(1'b1, 3'd6, 32'h12345678, 1'b0, 3'd0, 32'd0);
    tick();
    bus.ra1 = 3'd6; bus.rd1_in = 32'd0;
    bus.ra2 = 3'd7; bus.rd2_in = 32'hCAFEF00D;
    #1;
    chk("byp_rd1", bus.rd1_fwd, 32'h12345678);
    chk("byp_rd2", bus.rd2_fwd, 32'hCAFEF00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
